// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   NOP          : bubble instruction presented to decode when the queue is empty
//   ifq_state_e  : fetch control states
//   ifq_entry_t  : one buffered fetch result {PC+4, instruction word}
//   pc_plus4     : sequential next-PC helper (wraps modulo 2^32)
package ifq_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } ifq_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc_incr;
    logic [XLEN-1:0] instr;
  } ifq_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ifq_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched instructions.
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   i_push      : write i_wdata at the tail (caller guarantees room)
//   i_wdata     : entry to write
//   i_pop       : drop the head entry (caller guarantees non-empty)
//   i_clear     : empty the FIFO; wins over push and pop
//   o_head      : head entry (content undefined when o_count == 0)
//   o_count     : number of valid entries, 0..DEPTH
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  ifq_entry_t               i_wdata,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output ifq_entry_t               o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ifq_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Storage needs no reset: reads are qualified by the count.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end feeding the IF/ID register.
// Issues word fetches over a req/ack handshake, buffers returned words with
// their PC+4, and presents one instruction per cycle to decode.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   mem_req      : fetch request (registered), held until mem_ack
//   mem_addr     : address of the outstanding fetch (registered)
//   mem_ack      : memory completes the request this cycle
//   mem_rdata    : instruction word, valid with mem_ack
//   redirect     : taken branch/jump; flush queue and refetch
//   redirect_pc  : new fetch address, valid with redirect
//   stall        : decode cannot accept; hold the head
//   instr_out    : head instruction, NOP when empty
//   pc_incr_out  : PC+4 of the head instruction, 0 when empty
//   instr_valid  : head entry valid
module instr_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr_out,
  output logic [31:0] pc_incr_out,
  output logic        instr_valid
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  ifq_state_e       r_state;
  ifq_state_e       w_state_nxt;
  logic             r_mem_req;
  logic             w_mem_req_nxt;
  logic [31:0]      r_mem_addr;
  logic [31:0]      w_mem_addr_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      w_fetch_pc_nxt;

  logic             w_ack;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic             w_credit;
  logic             w_issue;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_count_nxt;
  ifq_entry_t       w_head;
  ifq_entry_t       w_wdata;

  // Handshake qualification: an ack only counts against a live request.
  assign w_ack   = mem_ack && r_mem_req;
  assign w_valid = (w_count != '0);
  // Only a non-stale completion is buffered; a coincident redirect drops it.
  assign w_push  = w_ack && (r_state == BUSY) && !redirect;
  assign w_pop   = w_valid && !stall && !redirect;

  assign w_wdata.pc_incr = pc_plus4(r_mem_addr);
  assign w_wdata.instr   = mem_rdata;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_clear (redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Occupancy after this edge; a new request needs a free slot for its ack.
  always_comb begin
    w_count_nxt = w_count;
    if (redirect) begin
      w_count_nxt = '0;
    end else begin
      w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign w_credit = (w_count_nxt < CNT_W'(DEPTH));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_credit) begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_ack) begin
          w_state_nxt = w_credit ? BUSY : IDLE;
        end else if (redirect) begin
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        if (w_ack) begin
          w_state_nxt = w_credit ? BUSY : IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output logic: next values of the request port and fetch PC.
  // fetch_pc doubles as the latched redirect target while in DISCARD.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_mem_req_nxt  = 1'b0;
    w_mem_addr_nxt = r_mem_addr;
    w_issue        = 1'b0;

    if (redirect) begin
      w_fetch_pc_nxt = redirect_pc;
    end else if (w_push) begin
      w_fetch_pc_nxt = pc_plus4(r_fetch_pc);
    end

    // A fresh request starts when entering BUSY from IDLE or after a completion.
    w_issue       = (w_state_nxt == BUSY) && ((r_state == IDLE) || w_ack);
    w_mem_req_nxt = (w_state_nxt != IDLE);
    if (w_issue) begin
      w_mem_addr_nxt = w_fetch_pc_nxt;
    end
  end

  // Request port and fetch PC registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign instr_valid = w_valid;
  assign instr_out   = w_valid ? w_head.instr : NOP;
  assign pc_incr_out = w_valid ? w_head.pc_incr : 32'd0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a vector table for the main flow
// plus hand-written sequences for full-queue stall, redirect with ack and reset.
module tb_instr_fetch_queue;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr_out;
  logic [31:0] pc_incr_out;
  logic        instr_valid;

  int checks;
  int failures;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pci;
  } vec_t;

  vec_t tbl [15];

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .instr_out   (instr_out),
    .pc_incr_out (pc_incr_out),
    .instr_valid (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " mem_req"},     32'(mem_req),     32'd0);
    check({tag, " mem_addr"},    mem_addr,         32'h0);
    check({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, " instr_out"},   instr_out,        32'd0);
    check({tag, " pc_incr_out"}, pc_incr_out,      32'd0);
  endtask

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic ak, input logic [31:0] rdat,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.stall = st;   v.redir = rd;    v.rpc = rpc;    v.ack = ak;      v.rdata = rdat;
    v.e_req = ereq; v.e_addr = eaddr; v.e_valid = ev; v.e_instr = ei; v.e_pci = ep;
    return v;
  endfunction

  // Responsive memory: acks every live request in its first cycle.
  task automatic mem_respond();
    mem_ack   = mem_req;
    mem_rdata = 32'h4000_0000 + (mem_addr >> 2);
  endtask

  initial begin
    int acks;
    checks   = 0;
    failures = 0;
    rst = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; stall = 1'b0;

    // Columns: stall redir rpc ack rdata | req addr valid instr pc_incr
    // Zero-wait fetches, then a 3-wait-cycle fetch, stall hold, redirect into DISCARD.
    tbl[0]  = mk(0,0,32'h0,  0,32'h0,         1'b0,32'h0,  0,32'h0,         32'h0);
    tbl[1]  = mk(0,0,32'h0,  1,32'h2000_0001, 1'b1,32'h0,  0,32'h0,         32'h0);
    tbl[2]  = mk(0,0,32'h0,  1,32'h2000_0002, 1'b1,32'h4,  1,32'h2000_0001, 32'h4);
    tbl[3]  = mk(0,0,32'h0,  1,32'h2000_0003, 1'b1,32'h8,  1,32'h2000_0002, 32'h8);
    tbl[4]  = mk(0,0,32'h0,  0,32'h0,         1'b1,32'hC,  1,32'h2000_0003, 32'hC);
    tbl[5]  = mk(0,0,32'h0,  0,32'h0,         1'b1,32'hC,  0,32'h0,         32'h0);
    tbl[6]  = mk(0,0,32'h0,  0,32'h0,         1'b1,32'hC,  0,32'h0,         32'h0);
    tbl[7]  = mk(0,0,32'h0,  1,32'h2000_0004, 1'b1,32'hC,  0,32'h0,         32'h0);
    tbl[8]  = mk(1,0,32'h0,  0,32'h0,         1'b1,32'h10, 1,32'h2000_0004, 32'h10);
    tbl[9]  = mk(1,0,32'h0,  0,32'h0,         1'b1,32'h10, 1,32'h2000_0004, 32'h10);
    tbl[10] = mk(1,1,32'h100,0,32'h0,         1'b1,32'h10, 1,32'h2000_0004, 32'h10);
    tbl[11] = mk(0,0,32'h0,  1,32'hDEAD_BEEF, 1'b1,32'h10, 0,32'h0,         32'h0);
    tbl[12] = mk(0,0,32'h0,  1,32'h1111_0000, 1'b1,32'h100,0,32'h0,         32'h0);
    tbl[13] = mk(0,0,32'h0,  0,32'h0,         1'b1,32'h104,1,32'h1111_0000, 32'h104);
    tbl[14] = mk(0,0,32'h0,  0,32'h0,         1'b1,32'h104,0,32'h0,         32'h0);

    tick();
    tick();
    check_reset("reset");
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      check($sformatf("row%0d mem_req", i),     32'(mem_req),     32'(tbl[i].e_req));
      check($sformatf("row%0d mem_addr", i),    mem_addr,         tbl[i].e_addr);
      check($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      check($sformatf("row%0d instr_out", i),   instr_out,        tbl[i].e_instr);
      check($sformatf("row%0d pc_incr_out", i), pc_incr_out,      tbl[i].e_pci);
      stall       = tbl[i].stall;
      redirect    = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      mem_ack     = tbl[i].ack;
      mem_rdata   = tbl[i].rdata;
      tick();
    end
    redirect = 1'b0; mem_ack = 1'b0; stall = 1'b0;

    // Redirect coincident with ack: data dropped, new address issued at once.
    check("ra pre mem_addr", mem_addr, 32'h104);
    redirect = 1'b1; redirect_pc = 32'h200; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    check("ra mem_req", 32'(mem_req), 32'd1);
    check("ra mem_addr", mem_addr, 32'h200);
    check("ra instr_valid", 32'(instr_valid), 32'd0);
    redirect = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h3333_0000;
    tick();
    check("ra2 instr_out", instr_out, 32'h3333_0000);
    check("ra2 pc_incr_out", pc_incr_out, 32'h204);
    check("ra2 mem_addr", mem_addr, 32'h204);
    mem_ack = 1'b0;

    // Stall with always-acking memory: exactly DEPTH acks, then request drops.
    rst = 1'b0;
    tick();
    check_reset("rst2");
    rst = 1'b1; stall = 1'b1;
    acks = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 1) begin
        check("first req", 32'(mem_req), 32'd1);
        check("first addr", mem_addr, 32'h0);
      end
      mem_respond();
      if (mem_ack) acks++;
      tick();
    end
    mem_ack = 1'b0;
    check("full acks", 32'(acks), 32'd4);
    check("full mem_req", 32'(mem_req), 32'd0);
    check("full instr_out", instr_out, 32'h4000_0000);
    check("full pc_incr_out", pc_incr_out, 32'h4);
    check("full instr_valid", 32'(instr_valid), 32'd1);

    // Release stall: back-to-back pops, fetching resumes at 0x10.
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("drain%0d instr_valid", k), 32'(instr_valid), 32'd1);
      check($sformatf("drain%0d instr_out", k), instr_out, 32'h4000_0000 + 32'(k));
      check($sformatf("drain%0d pc_incr_out", k), pc_incr_out, 32'(4 * k + 4));
      if (k == 1) begin
        check("resume mem_req", 32'(mem_req), 32'd1);
        check("resume mem_addr", mem_addr, 32'h10);
      end
      mem_respond();
      tick();
    end
    mem_ack = 1'b0;

    // Reset mid-request with two entries buffered; a late ack is ignored.
    rst = 1'b0;
    tick();
    rst = 1'b1; stall = 1'b1; mem_ack = 1'b0;
    tick();
    mem_respond();
    tick();
    mem_respond();
    tick();
    mem_ack = 1'b0;
    check("mid req", 32'(mem_req), 32'd1);
    check("mid addr", mem_addr, 32'h8);
    check("mid instr_out", instr_out, 32'h4000_0000);
    rst = 1'b0;
    tick();
    check_reset("midrst");
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
    tick();
    mem_ack = 1'b0;
    check("post req", 32'(mem_req), 32'd1);
    check("post addr", mem_addr, 32'h0);
    check("post instr_valid", 32'(instr_valid), 32'd0);
    check("post instr_out", instr_out, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
